// File: rtl/add_1bit.sv
// add_1bit: full adder cell, generalised to a WIDTH-bit ripple-carry adder.
//
// Computes {ret, s} = a + b + r at WIDTH+1 bits. No overflow is lost.
// REG_OUT=1 registers the result with 1-cycle latency. A new sample is taken
// on every rising clk edge, with no handshake or stall. REG_OUT=0 produces
// the result purely combinationally, and clk/rst are unused.
//
// Ports:
//   clk  in   1      rising-edge clock (used only when REG_OUT=1)
//   rst  in   1      asynchronous active-high reset; clears s/ret
//   a    in   WIDTH  operand A
//   b    in   WIDTH  operand B
//   r    in   1      carry-in
//   s    out  WIDTH  sum, a + b + r modulo 2**WIDTH
//   ret  out  1      carry-out, bit WIDTH of a + b + r
module add_1bit #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             r,
  output logic [WIDTH-1:0] s,
  output logic             ret
);

  // Carry chain: c[0] is the carry-in, and c[WIDTH] is the carry-out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_p0;

  assign c[0] = r;

  // Stage p0: ripple of explicit full-adder cells, bit 0 first.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum_p0[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1]    = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] s_p1;
    logic             ret_p1;

    // Stage p1: output register. The reset is asynchronous, so s/ret clear
    // as soon as rst rises, and any pending result is dropped.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_p1   <= '0;
        ret_p1 <= 1'b0;
      end else begin
        s_p1   <= sum_p0;
        ret_p1 <= c[WIDTH];
      end
    end

    assign s   = s_p1;
    assign ret = ret_p1;
  end else begin : g_comb
    // clk and rst have no function in the combinational build.
    logic unused_ctl;
    assign unused_ctl = clk | rst;

    assign s   = sum_p0;
    assign ret = c[WIDTH];
  end

endmodule

// File: tb/tb_add_1bit.sv
module tb_add_1bit;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;

  // WIDTH=1, registered
  logic a1 = 1'b0, b1 = 1'b0, r1 = 1'b0;
  logic s1, ret1;
  // WIDTH=4, registered
  logic [3:0] a4 = 4'h0, b4 = 4'h0;
  logic r4 = 1'b0;
  logic [3:0] s4;
  logic ret4;
  // WIDTH=1, combinational
  logic ac = 1'b0, bc = 1'b0, rc = 1'b0;
  logic sc, retc;

  int n_checks = 0;
  int n_fail = 0;

  add_1bit #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .r(r1), .s(s1), .ret(ret1)
  );

  add_1bit #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .r(r4), .s(s4), .ret(ret4)
  );

  add_1bit #(.WIDTH(1), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst(rst), .a(ac), .b(bc), .r(rc), .s(sc), .ret(retc)
  );

  initial forever #5 clk = clk_en ? ~clk : 1'b0;

  task automatic test_reset();
    a1 = 1'b1; b1 = 1'b1; r1 = 1'b1;
    a4 = 4'hF; b4 = 4'hF; r4 = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (s1 !== 1'b0 || ret1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_w1: got s=%b ret=%b, want s=0 ret=0", s1, ret1);
    end
    n_checks++;
    if (s4 !== 4'h0 || ret4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_w4: got s=%h ret=%b, want s=0 ret=0", s4, ret4);
    end
    clk_en = 1'b1;
    // While rst is held, clock edges must not load the inputs.
    @(posedge clk); #1;
    n_checks++;
    if (s1 !== 1'b0 || ret1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got s=%b ret=%b, want s=0 ret=0", s1, ret1);
    end
  endtask

  task automatic test_truth_table();
    logic [2:0] vec [8];
    logic [1:0] exp [8];  // {ret, s}
    vec[0] = 3'b000; exp[0] = 2'b00;
    vec[1] = 3'b100; exp[1] = 2'b01;
    vec[2] = 3'b110; exp[2] = 2'b10;
    vec[3] = 3'b111; exp[3] = 2'b11;
    vec[4] = 3'b101; exp[4] = 2'b10;
    vec[5] = 3'b011; exp[5] = 2'b10;
    vec[6] = 3'b010; exp[6] = 2'b01;
    vec[7] = 3'b001; exp[7] = 2'b01;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, r1} = vec[i];
      @(posedge clk); #1;
      n_checks++;
      if ({ret1, s1} !== exp[i]) begin
        n_fail++;
        $display("FAIL truth_%b: got ret=%b s=%b, want ret=%b s=%b",
                 vec[i], ret1, s1, exp[i][1], exp[i][0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_latency();
    a1 = 1'b0; b1 = 1'b0; r1 = 1'b0;
    @(posedge clk); #2;
    a1 = 1'b1;
    #1;
    n_checks++;
    if (s1 !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_mid: got s=%b, want s=0 before edge", s1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (s1 !== 1'b1 || ret1 !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_edge: got s=%b ret=%b, want s=1 ret=0", s1, ret1);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; r1 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (s1 !== 1'b0 || ret1 !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: got s=%b ret=%b, want s=0 ret=0", s1, ret1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (s1 !== 1'b0 || ret1 !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_edge: got s=%b ret=%b, want s=0 ret=0", s1, ret1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (s1 !== 1'b0 || ret1 !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_release: got s=%b ret=%b, want s=0 ret=1", s1, ret1);
    end
  endtask

  task automatic test_width4();
    logic [8:0] vec [5];  // {a, b, r}
    logic [4:0] exp [5];  // {ret, s}
    vec[0] = {4'hF, 4'h0, 1'b1}; exp[0] = {1'b1, 4'h0};
    vec[1] = {4'h9, 4'h6, 1'b0}; exp[1] = {1'b0, 4'hF};
    vec[2] = {4'hF, 4'hF, 1'b1}; exp[2] = {1'b1, 4'hF};
    vec[3] = {4'h0, 4'h0, 1'b0}; exp[3] = {1'b0, 4'h0};
    vec[4] = {4'h5, 4'h3, 1'b1}; exp[4] = {1'b0, 4'h9};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      {a4, b4, r4} = vec[i];
      @(posedge clk); #1;
      n_checks++;
      if ({ret4, s4} !== exp[i]) begin
        n_fail++;
        $display("FAIL w4_vec%0d: got ret=%b s=%h, want ret=%b s=%h",
                 i, ret4, s4, exp[i][4], exp[i][3:0]);
      end
    end
  endtask

  task automatic test_comb();
    // Indexed by {a, b, r}.
    logic [7:0] s_tab;
    logic [7:0] ret_tab;
    s_tab   = 8'b1001_0110;
    ret_tab = 8'b1110_1000;
    clk_en = 1'b0;
    #7;
    for (int i = 0; i < 8; i++) begin
      {ac, bc, rc} = 3'(i);
      #1;
      n_checks++;
      if (sc !== s_tab[i] || retc !== ret_tab[i]) begin
        n_fail++;
        $display("FAIL comb_%b: got s=%b ret=%b, want s=%b ret=%b",
                 3'(i), sc, retc, s_tab[i], ret_tab[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_latency();
    test_reset_midstream();
    test_width4();
    test_comb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
